// File: rtl/tone_pkg.sv
// Shared tone codes, half-period lookup and scheduler state encoding.
package tone_pkg;

  localparam int unsigned TONE_W = 3;
  localparam int unsigned HP_W   = 4;

  localparam logic [TONE_W-1:0] TONE_RED    = 3'd0;
  localparam logic [TONE_W-1:0] TONE_GREEN  = 3'd1;
  localparam logic [TONE_W-1:0] TONE_YELLOW = 3'd2;
  localparam logic [TONE_W-1:0] TONE_BLUE   = 3'd3;
  localparam logic [TONE_W-1:0] TONE_WIN    = 3'd4;
  localparam logic [TONE_W-1:0] TONE_LOSS   = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Half period in cycles; 0 marks a silent code.
  function automatic logic [HP_W-1:0] tone_hp(input logic [TONE_W-1:0] code);
    logic [HP_W-1:0] hp;
    case (code)
      TONE_RED:    hp = 4'd4;
      TONE_GREEN:  hp = 4'd5;
      TONE_YELLOW: hp = 4'd6;
      TONE_BLUE:   hp = 4'd7;
      TONE_WIN:    hp = 4'd8;
      TONE_LOSS:   hp = 4'd3;
      default:     hp = 4'd0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: toggles speaker every tone_hp(code) cycles while run is high.
module tone_div
  import tone_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [TONE_W-1:0] code,
  input  logic              run,
  output logic              speaker
);

  logic [2:0]      hcnt;
  logic [HP_W-1:0] hp;

  assign hp = tone_hp(code);

  // run low (idle, gap, or leaving PLAY) parks the divider at phase 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt    <= '0;
      speaker <= 1'b0;
    end else if (!run || hp == '0) begin
      hcnt    <= '0;
      speaker <= 1'b0;
    end else if ({1'b0, hcnt} == hp - 4'd1) begin
      hcnt    <= '0;
      speaker <= ~speaker;
    end else begin
      hcnt <= hcnt + 3'd1;
    end
  end

endmodule

// File: rtl/tone_sched.sv
// Round-robin scheduler sharing one speaker tone generator among NUM_REQ requesters.
module tone_sched
  import tone_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DUR_W   = 6,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [TONE_W*NUM_REQ-1:0] tone,
  input  logic [DUR_W*NUM_REQ-1:0] dur,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [TONE_W-1:0]        cur_tone,
  output logic                     speaker
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [IDX_W-1:0]   win, win_nxt;
  logic [DUR_W-1:0]   dcnt, dcnt_nxt;
  logic [GAP_W-1:0]   gcnt, gcnt_nxt;
  logic               aborted, aborted_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
  logic               busy_nxt;
  logic [TONE_W-1:0]  tone_nxt;

  logic               found;
  logic [IDX_W-1:0]   pick, cand;
  logic [DUR_W-1:0]   pick_dur;
  logic               run;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    pick_dur = dur[DUR_W*pick +: DUR_W];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    win_nxt     = win;
    dcnt_nxt    = dcnt;
    gcnt_nxt    = gcnt;
    aborted_nxt = aborted;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    tone_nxt    = cur_tone;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        tone_nxt = '0;
        if (found) begin
          win_nxt     = pick;
          rr_nxt      = IDX_W'((32'(pick) + 1) % NUM_REQ);
          gnt_nxt     = NUM_REQ'(1) << pick;
          tone_nxt    = tone[TONE_W*pick +: TONE_W];
          dcnt_nxt    = pick_dur;
          aborted_nxt = 1'b0;
          if (pick_dur != '0) begin
            state_nxt = PLAY;
          end else begin
            state_nxt = GAP;
            gcnt_nxt  = GAP_W'(GAP_CYC - 1);
          end
        end
      end
      PLAY: begin
        dcnt_nxt = dcnt - DUR_W'(1);
        if (!req[win]) begin
          state_nxt   = GAP;
          gcnt_nxt    = GAP_W'(GAP_CYC - 1);
          aborted_nxt = 1'b1;
        end else if (dcnt == DUR_W'(1)) begin
          state_nxt = GAP;
          gcnt_nxt  = GAP_W'(GAP_CYC - 1);
        end
      end
      GAP: begin
        if (gcnt == '0) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          tone_nxt  = '0;
          done_nxt  = aborted ? '0 : gnt;
        end else begin
          gcnt_nxt = gcnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        tone_nxt  = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win      <= '0;
      dcnt     <= '0;
      gcnt     <= '0;
      aborted  <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      cur_tone <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      win      <= win_nxt;
      dcnt     <= dcnt_nxt;
      gcnt     <= gcnt_nxt;
      aborted  <= aborted_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      cur_tone <= tone_nxt;
    end
  end

  // Divider advances only while staying in PLAY, so speaker is 0 on PLAY entry and in GAP.
  assign run = (state == PLAY) && (state_nxt == PLAY);

  tone_div u_div (
    .clock   (clock),
    .reset   (reset),
    .code    (cur_tone),
    .run     (run),
    .speaker (speaker)
  );

endmodule

// File: tb/tb_tone_sched.sv
// Directed plus randomized check of tone_sched against a transaction-level reference.
module tb_tone_sched;

  localparam int N   = 3;
  localparam int DW  = 6;
  localparam int GAP = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req   = '0;
  logic [3*N-1:0] tone = '0;
  logic [DW*N-1:0] dur = '0;
  logic [N-1:0]  gnt, done;
  logic          busy;
  logic [2:0]    cur_tone;
  logic          speaker;

  int tests = 0;
  int fails = 0;
  int rr    = 0;
  int hp_tab [8] = '{4, 5, 6, 7, 8, 3, 0, 0};
  int pc [N];
  int pd [N];

  tone_sched #(.NUM_REQ(N), .DUR_W(DW), .GAP_CYC(GAP)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .tone     (tone),
    .dur      (dur),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .cur_tone (cur_tone),
    .speaker  (speaker)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  // Speaker level in 1-based PLAY cycle k: starts low, flips every HP cycles.
  function automatic logic exp_spk(input int code, input int k);
    if (hp_tab[code] == 0) return 1'b0;
    return ((k - 1) / hp_tab[code]) % 2 == 1;
  endfunction

  task automatic set_src(input int i, input int code, input int d);
    tone[3*i +: 3] = 3'(code);
    dur[DW*i +: DW] = DW'(d);
  endtask

  // Entered in the IDLE cycle where w is requesting; returns in the completion cycle.
  task automatic serve(input int w, input int code, input int d, input int abort_at, input bit scramble);
    logic [N-1:0] oh;
    bit ab;
    oh = N'(1) << w;
    ab = 1'b0;
    step();
    rr = (w + 1) % N;
    chk("grant", 32'(gnt), 32'(oh));
    chk("busy_grant", 32'(busy), 1);
    chk("cur_tone_grant", 32'(cur_tone), 32'(code));
    chk("done_grant", 32'(done), 0);
    for (int k = 1; k <= d; k++) begin
      chk("spk_play", 32'(speaker), 32'(exp_spk(code, k)));
      chk("gnt_play", 32'(gnt), 32'(oh));
      chk("cur_tone_play", 32'(cur_tone), 32'(code));
      chk("done_play", 32'(done), 0);
      if (scramble) set_src(w, int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
      if (k == abort_at) begin
        req[w] = 1'b0;
        ab = 1'b1;
        step();
        break;
      end
      step();
    end
    for (int g = 0; g < GAP; g++) begin
      chk("spk_gap", 32'(speaker), 0);
      chk("gnt_gap", 32'(gnt), 32'(oh));
      chk("busy_gap", 32'(busy), 1);
      chk("done_gap", 32'(done), 0);
      if (scramble && $urandom_range(0, 1) == 1) req[w] = 1'b0;
      step();
    end
    chk("done", 32'(done), ab ? 0 : 32'(oh));
    chk("gnt_idle", 32'(gnt), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("cur_tone_idle", 32'(cur_tone), 0);
    chk("spk_idle", 32'(speaker), 0);
  endtask

  initial begin
    int w;
    int ab;
    logic [N-1:0] saved;

    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_spk", 32'(speaker), 0);
    chk("rst_tone", 32'(cur_tone), 0);
    reset = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Single tone, code 0, 16 cycles.
    set_src(0, 0, 16);
    req = 3'b001;
    serve(pick(req), 0, 16, 0, 1'b0);
    req = '0;
    step();
    chk("done_once", 32'(done), 0);

    // Zero duration goes straight to GAP.
    set_src(1, 4, 0);
    req = 3'b010;
    serve(pick(req), 4, 0, 0, 1'b0);
    req = '0;
    step();

    // Abort in PLAY cycle 5.
    set_src(2, 5, 20);
    req = 3'b100;
    serve(pick(req), 5, 20, 5, 1'b0);
    step();
    chk("abort_idle_busy", 32'(busy), 0);
    chk("abort_no_done", 32'(done), 0);

    // All three held: strict rotation, back-to-back grants.
    for (int i = 0; i < N; i++) set_src(i, i, 4);
    req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      w = pick(req);
      chk("rotation", 32'(w), 32'(n % N));
      serve(w, w, 4, 0, 1'b0);
    end
    req = '0;
    step();

    // Silent code still timed.
    set_src(0, 6, 8);
    req = 3'b001;
    serve(pick(req), 6, 8, 0, 1'b0);
    req = '0;

    // Maximum duration.
    set_src(1, 3, 63);
    req = 3'b010;
    serve(pick(req), 3, 63, 0, 1'b0);
    req = '0;
    step();

    // Reset in the middle of a tone while speaker is high.
    set_src(0, 0, 30);
    req = 3'b001;
    step();
    chk("pre_rst_gnt", 32'(gnt), 1);
    for (int k = 0; k < 5; k++) step();
    chk("pre_rst_spk", 32'(speaker), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_spk", 32'(speaker), 0);
    chk("mid_rst_tone", 32'(cur_tone), 0);
    chk("mid_rst_done", 32'(done), 0);
    req = '0;
    step();
    reset = 1'b1;
    rr = 0;
    for (int k = 0; k < GAP + 3; k++) begin
      step();
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_done", 32'(done), 0);
    end

    // Randomized traffic against the reference.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) != 0) begin
          pc[i] = int'($urandom_range(0, 7));
          pd[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 24));
          set_src(i, pc[i], pd[i]);
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        pc[it % N] = 1;
        pd[it % N] = 5;
        set_src(it % N, 1, 5);
        req[it % N] = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) begin
        saved = req;
        req = '0;
        step();
        chk("rand_idle_busy", 32'(busy), 0);
        chk("rand_idle_gnt", 32'(gnt), 0);
        req = saved;
      end
      w = pick(req);
      ab = (pd[w] > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, pd[w])) : 0;
      serve(w, pc[w], pd[w], ab, 1'b1);
      req[w] = 1'b0;
    end

    req = '0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
